// File: rtl/pool_frame_scheduler_if.sv
// Handshake and status bundle between the frame scheduler and its environment.
// master drives requests/pixels/pooling feedback, slave is the scheduler itself.
interface pool_frame_scheduler_if #(
  parameter int W_WIDTH  = 640,
  parameter int W_HEIGHT = 480,
  parameter int NUM_REQ  = 2
);
  localparam int H_BITW     = $clog2(W_WIDTH);
  localparam int V_BITW     = $clog2(W_HEIGHT);
  localparam int ID_BITW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int EXPECT_OUT = (W_WIDTH / 2) * (W_HEIGHT / 2);
  localparam int CNT_BITW   = $clog2(EXPECT_OUT + 1);

  logic [NUM_REQ-1:0]  req;
  logic                src_valid;
  logic                abort;
  logic                pool_out_enable;
  logic [NUM_REQ-1:0]  grant;
  logic                frame_start;
  logic                pool_enable;
  logic [V_BITW-1:0]   pool_vcnt;
  logic [H_BITW-1:0]   pool_hcnt;
  logic                busy;
  logic                frame_done;
  logic [ID_BITW-1:0]  done_id;
  logic [CNT_BITW-1:0] pooled_count;
  logic                count_err;
  logic                aborted;

  modport master (
    output req, src_valid, abort, pool_out_enable,
    input  grant, frame_start, pool_enable, pool_vcnt, pool_hcnt, busy,
           frame_done, done_id, pooled_count, count_err, aborted
  );

  modport slave (
    input  req, src_valid, abort, pool_out_enable,
    output grant, frame_start, pool_enable, pool_vcnt, pool_hcnt, busy,
           frame_done, done_id, pooled_count, count_err, aborted
  );
endinterface

// File: rtl/pool_frame_scheduler.sv
// Frame-level round-robin scheduler sharing one maxpooling layer between
// NUM_REQ sources: grants whole frames, rasterises the accepted pixels,
// drains the pooling pipeline and reports per-frame completion status.
module pool_frame_scheduler #(
  parameter int W_WIDTH      = 640,
  parameter int W_HEIGHT     = 480,
  parameter int NUM_REQ      = 2,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  pool_frame_scheduler_if.slave bus
);
  localparam int H_BITW     = $clog2(W_WIDTH);
  localparam int V_BITW     = $clog2(W_HEIGHT);
  localparam int ID_BITW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int EXPECT_OUT = (W_WIDTH / 2) * (W_HEIGHT / 2);
  localparam int CNT_BITW   = $clog2(EXPECT_OUT + 1);
  localparam int DR_BITW    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                frame_start_q, frame_start_d;
  logic                pool_enable_q, pool_enable_d;
  logic [V_BITW-1:0]   pool_vcnt_q, pool_vcnt_d;
  logic [H_BITW-1:0]   pool_hcnt_q, pool_hcnt_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic [ID_BITW-1:0]  done_id_q, done_id_d;
  logic [CNT_BITW-1:0] pooled_count_q, pooled_count_d;
  logic                count_err_q, count_err_d;
  logic                aborted_q, aborted_d;
  // internal raster position, output counter, drain timer, frame owner
  logic [H_BITW-1:0]   h_q, h_d;
  logic [V_BITW-1:0]   v_q, v_d;
  logic [CNT_BITW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [DR_BITW-1:0]  drain_q, drain_d;
  logic [ID_BITW-1:0]  id_q, id_d;
  logic                abt_q, abt_d;
  logic [ID_BITW-1:0]  last_id_q, last_id_d;

  logic [ID_BITW-1:0]  winner;
  logic                found;
  logic [NUM_REQ-1:0]  win_onehot;

  // round-robin pick: first requester after the previous winner
  always_comb begin : rr_pick
    int idx;
    winner = last_id_q;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_id_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx]) begin
        winner = ID_BITW'(idx);
        found  = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign win_onehot[gi] = (winner == ID_BITW'(gi));
  end

  // saturating pooled-output counter increment
  always_comb begin
    cnt_inc = cnt_q;
    if (bus.pool_out_enable && (cnt_q != {CNT_BITW{1'b1}})) cnt_inc = cnt_q + 1'b1;
  end

  // frame FSM, raster generation and status capture
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    frame_start_d  = 1'b0;
    pool_enable_d  = 1'b0;
    pool_vcnt_d    = pool_vcnt_q;
    pool_hcnt_d    = pool_hcnt_q;
    frame_done_d   = 1'b0;
    done_id_d      = '0;
    pooled_count_d = '0;
    count_err_d    = 1'b0;
    aborted_d      = 1'b0;
    h_d            = h_q;
    v_d            = v_q;
    cnt_d          = cnt_q;
    drain_d        = drain_q;
    id_d           = id_q;
    abt_d          = abt_q;
    last_id_d      = last_id_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (|bus.req) begin
          state_d       = S_RUN;
          grant_d       = win_onehot;
          frame_start_d = 1'b1;
          h_d           = '0;
          v_d           = '0;
          cnt_d         = '0;
          id_d          = winner;
          abt_d         = 1'b0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (bus.abort) begin
          // abort beats a pixel offered in the same cycle
          state_d = S_DRAIN;
          drain_d = '0;
          abt_d   = 1'b1;
        end else if (bus.src_valid) begin
          pool_enable_d = 1'b1;
          pool_vcnt_d   = v_q;
          pool_hcnt_d   = h_q;
          if (h_q == H_BITW'(W_WIDTH - 1)) begin
            h_d = '0;
            if (v_q == V_BITW'(W_HEIGHT - 1)) begin
              state_d = S_DRAIN;
              drain_d = '0;
            end else begin
              v_d = v_q + 1'b1;
            end
          end else begin
            h_d = h_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_inc;
        if (drain_q == DR_BITW'(DRAIN_CYCLES - 1)) begin
          state_d        = S_DONE;
          frame_done_d   = 1'b1;
          done_id_d      = id_q;
          pooled_count_d = cnt_inc;
          count_err_d    = (cnt_inc != CNT_BITW'(EXPECT_OUT));
          aborted_d      = abt_q;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        grant_d   = '0;
        last_id_d = id_q;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // state and output registers
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q        <= S_IDLE;
      grant_q        <= '0;
      frame_start_q  <= 1'b0;
      pool_enable_q  <= 1'b0;
      pool_vcnt_q    <= '0;
      pool_hcnt_q    <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      done_id_q      <= '0;
      pooled_count_q <= '0;
      count_err_q    <= 1'b0;
      aborted_q      <= 1'b0;
      h_q            <= '0;
      v_q            <= '0;
      cnt_q          <= '0;
      drain_q        <= '0;
      id_q           <= '0;
      abt_q          <= 1'b0;
      last_id_q      <= ID_BITW'(NUM_REQ - 1);
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      frame_start_q  <= frame_start_d;
      pool_enable_q  <= pool_enable_d;
      pool_vcnt_q    <= pool_vcnt_d;
      pool_hcnt_q    <= pool_hcnt_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      done_id_q      <= done_id_d;
      pooled_count_q <= pooled_count_d;
      count_err_q    <= count_err_d;
      aborted_q      <= aborted_d;
      h_q            <= h_d;
      v_q            <= v_d;
      cnt_q          <= cnt_d;
      drain_q        <= drain_d;
      id_q           <= id_d;
      abt_q          <= abt_d;
      last_id_q      <= last_id_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.pool_enable  = pool_enable_q;
  assign bus.pool_vcnt    = pool_vcnt_q;
  assign bus.pool_hcnt    = pool_hcnt_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.done_id      = done_id_q;
  assign bus.pooled_count = pooled_count_q;
  assign bus.count_err    = count_err_q;
  assign bus.aborted      = aborted_q;
endmodule

// File: tb/tb_pool_frame_scheduler.sv
// Directed bench for pool_frame_scheduler on an 8x4 frame, two sources,
// six drain cycles. A tiny maxpooling stand-in raises pool_out_enable for
// every enabled pixel at odd (vcnt,hcnt), giving 8 outputs per full frame.
module tb_pool_frame_scheduler;
  localparam int W = 8;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst;
  logic extra_poe;

  pool_frame_scheduler_if #(.W_WIDTH(W), .W_HEIGHT(H), .NUM_REQ(2)) bus ();

  pool_frame_scheduler #(.W_WIDTH(W), .W_HEIGHT(H), .NUM_REQ(2), .DRAIN_CYCLES(6)) dut (
    .clock (clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic       sv;
    logic       ab;
    logic [1:0] grant;
    logic       busy;
    logic       fs;
    logic       pe;
    logic [1:0] v;
    logic [2:0] h;
  } vec_t;

  vec_t vecs [5];

  int checks = 0, errors = 0, cyc = 0;
  int en_cnt = 0, last_en_cyc = 0, exp_h = 0, exp_v = 0, last_h = 0, last_v = 0;
  int fd_n = 0, fd_cyc = 0, fd_id = 0, fd_count = 0, fd_err = 0, fd_ab = 0;
  int abort_cyc = 0, fd_before = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one clock: drive pooling feedback, advance, then observe outputs
  task automatic tick();
    bus.pool_out_enable = extra_poe |
                          (bus.pool_enable & bus.pool_vcnt[0] & bus.pool_hcnt[0]);
    @(posedge clk);
    #1;
    cyc++;
    if (bus.frame_start) begin
      exp_h = 0; exp_v = 0; en_cnt = 0;
    end
    if (bus.pool_enable) begin
      chk("raster_v", int'(bus.pool_vcnt), exp_v);
      chk("raster_h", int'(bus.pool_hcnt), exp_h);
      last_v = exp_v; last_h = exp_h;
      en_cnt++; last_en_cyc = cyc;
      exp_h++;
      if (exp_h == W) begin exp_h = 0; exp_v++; end
    end
    if (bus.frame_done) begin
      fd_n++; fd_cyc = cyc;
      fd_id = int'(bus.done_id); fd_count = int'(bus.pooled_count);
      fd_err = int'(bus.count_err); fd_ab = int'(bus.aborted);
      $display("frame %0d done: id=%0d count=%0d err=%0d aborted=%0d enables=%0d",
               fd_n, fd_id, fd_count, fd_err, fd_ab, en_cnt);
    end
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    do begin tick(); n++; end while (!bus.frame_start && n < budget);
    chk("frame_start_seen", int'(bus.frame_start), 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin tick(); n++; end while (!bus.frame_done && n < budget);
    chk("frame_done_seen", int'(bus.frame_done), 1);
  endtask

  task automatic check_frame(input int id, input int cnt, input int err, input int ab);
    chk("done_id", fd_id, id);
    chk("pooled_count", fd_count, cnt);
    chk("count_err", fd_err, err);
    chk("aborted", fd_ab, ab);
  endtask

  // run an accepted frame until en_cnt enables, then abort with a pixel offered
  task automatic abort_after(input int n_en, input int exp_cnt);
    int n = 0;
    bus.req = 2'b01; bus.src_valid = 1'b1;
    wait_start(20);
    bus.req = 2'b00;
    while (en_cnt < n_en && n < 100) begin tick(); n++; end
    chk("abort_pos_reached", en_cnt, n_en);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    abort_cyc = cyc;
    chk("abort_pe_low", int'(bus.pool_enable), 0);
    wait_done(50);
    chk("abort_drain_len", fd_cyc - abort_cyc, 6);
    chk("abort_enables", en_cnt, n_en);
    check_frame(0, exp_cnt, 1, 1);
  endtask

  initial begin
    vecs[0] = '{req:2'b01, sv:1'b1, ab:1'b0, grant:2'b01, busy:1'b1, fs:1'b1, pe:1'b0, v:2'd0, h:3'd0};
    vecs[1] = '{req:2'b01, sv:1'b1, ab:1'b0, grant:2'b01, busy:1'b1, fs:1'b0, pe:1'b1, v:2'd0, h:3'd0};
    vecs[2] = '{req:2'b00, sv:1'b1, ab:1'b0, grant:2'b01, busy:1'b1, fs:1'b0, pe:1'b1, v:2'd0, h:3'd1};
    vecs[3] = '{req:2'b00, sv:1'b0, ab:1'b0, grant:2'b01, busy:1'b1, fs:1'b0, pe:1'b0, v:2'd0, h:3'd1};
    vecs[4] = '{req:2'b00, sv:1'b1, ab:1'b0, grant:2'b01, busy:1'b1, fs:1'b0, pe:1'b1, v:2'd0, h:3'd2};

    rst = 1'b1; extra_poe = 1'b0;
    bus.req = 2'b00; bus.src_valid = 1'b0; bus.abort = 1'b0; bus.pool_out_enable = 1'b0;
    repeat (3) tick();
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_pe", int'(bus.pool_enable), 0);
    chk("rst_fs", int'(bus.frame_start), 0);
    chk("rst_fd", int'(bus.frame_done), 0);
    chk("rst_count", int'(bus.pooled_count), 0);
    rst = 1'b0;

    // T1: first cycles from the vector table, then finish the frame
    for (int i = 0; i < 5; i++) begin
      bus.req = vecs[i].req; bus.src_valid = vecs[i].sv; bus.abort = vecs[i].ab;
      tick();
      chk("vec_grant", int'(bus.grant), int'(vecs[i].grant));
      chk("vec_busy", int'(bus.busy), int'(vecs[i].busy));
      chk("vec_fs", int'(bus.frame_start), int'(vecs[i].fs));
      chk("vec_pe", int'(bus.pool_enable), int'(vecs[i].pe));
      chk("vec_vcnt", int'(bus.pool_vcnt), int'(vecs[i].v));
      chk("vec_hcnt", int'(bus.pool_hcnt), int'(vecs[i].h));
    end
    bus.src_valid = 1'b1;
    wait_done(100);
    chk("t1_enables", en_cnt, 32);
    chk("t1_drain_len", fd_cyc - last_en_cyc, 6);
    chk("t1_grant_in_done", int'(bus.grant), 1);
    check_frame(0, 8, 0, 0);
    tick();
    chk("t1_idle_busy", int'(bus.busy), 0);
    chk("t1_idle_grant", int'(bus.grant), 0);

    // T2: both sources requesting, alternating grants from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req = 2'b11; bus.src_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_start(20);
      chk("t2_grant", int'(bus.grant), (f % 2 == 0) ? 1 : 2);
      wait_done(100);
      check_frame(f % 2, 8, 0, 0);
      tick();
      chk("t2_idle_gap", int'(bus.busy), 0);
    end

    // T3: src_valid alternating, coordinates hold while no pixel
    bus.req = 2'b01; bus.src_valid = 1'b1;
    wait_start(20);
    bus.req = 2'b00;
    begin
      int n = 0;
      while (!bus.frame_done && n < 200) begin
        bus.src_valid = ~bus.src_valid;
        tick(); n++;
        if (!bus.pool_enable && en_cnt > 0 && !bus.frame_done) begin
          chk("t3_hold_v", int'(bus.pool_vcnt), last_v);
          chk("t3_hold_h", int'(bus.pool_hcnt), last_h);
        end
      end
    end
    chk("t3_frame_done_seen", int'(bus.frame_done), 1);
    chk("t3_enables", en_cnt, 32);
    chk("t3_drain_len", fd_cyc - last_en_cyc, 6);
    check_frame(0, 8, 0, 0);

    // T4: abort at (1,3); then abort together with the last pixel
    abort_after(11, 1);
    abort_after(31, 7);

    // T5: reset mid-RUN loses the frame, pointer restarts
    bus.req = 2'b01; bus.src_valid = 1'b1;
    wait_start(20);
    repeat (5) tick();
    fd_before = fd_n;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_grant", int'(bus.grant), 0);
    chk("t5_busy", int'(bus.busy), 0);
    chk("t5_pe", int'(bus.pool_enable), 0);
    bus.req = 2'b00;
    repeat (10) tick();
    chk("t5_no_lost_done", fd_n, fd_before);
    bus.req = 2'b10;
    wait_start(20);
    chk("t5_grant_src1", int'(bus.grant), 2);
    bus.req = 2'b00;
    wait_done(100);
    check_frame(1, 8, 0, 0);

    // T6: pulses in IDLE ignored, one extra pulse inside the frame
    tick();
    extra_poe = 1'b1;
    repeat (3) tick();
    extra_poe = 1'b0;
    chk("t6_idle_count", int'(bus.pooled_count), 0);
    bus.req = 2'b01; bus.src_valid = 1'b1;
    wait_start(20);
    bus.req = 2'b00;
    extra_poe = 1'b1; tick(); extra_poe = 1'b0;
    wait_done(100);
    check_frame(0, 9, 1, 0);

    // T7: pool_out_enable stuck high saturates the counter
    bus.req = 2'b01;
    wait_start(20);
    bus.req = 2'b00;
    extra_poe = 1'b1;
    wait_done(100);
    extra_poe = 1'b0;
    check_frame(0, 15, 1, 0);
    tick();
    chk("t7_idle_count", int'(bus.pooled_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
